// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory bus port between instruction fetch (IF)
// and the load/store path (LS). One transaction outstanding at a time; LS has
// priority with a bounded burst so fetch cannot starve. Builds byte enables and
// lane-replicated store data, and aligns/extends load data on the way back.
module mem_arbiter #(
    parameter int unsigned LS_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        ls_req_i,
    input  logic        ls_rw_i,
    input  logic [1:0]  ls_width_i,
    input  logic        ls_rdtype_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_err_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [3:0] BurstMax = 4'(LS_BURST_MAX);

    // Width encoding from the control unit.
    localparam logic [1:0] WidthByte = 2'd1;
    localparam logic [1:0] WidthHalf = 2'd2;
    localparam logic [1:0] WidthWord = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StWaitI,
        StWaitD
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    // Lock holds the selection while bus_req_o is up but not yet granted.
    logic        lock_q, lock_d;
    logic        lock_ls_q, lock_ls_d;
    // LS transaction attributes kept for the response phase.
    logic        rw_q, rw_d;
    logic        rdtype_q, rdtype_d;
    logic [1:0]  width_q, width_d;
    logic [1:0]  off_q, off_d;

    logic        sel_if;
    logic        sel_ls;
    logic        ls_bad;
    logic        bus_req;
    logic [3:0]  ls_be;
    logic [31:0] ls_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    // Fetch addresses are word aligned by contract; low bits carry no meaning.
    logic unused_if_addr;
    assign unused_if_addr = ^if_addr_i[1:0];

    // Requester selection in IDLE: lock first, then LS priority bounded by starve count.
    always_comb begin
        sel_if = 1'b0;
        sel_ls = 1'b0;
        if (state_q == StIdle) begin
            if (lock_q) begin
                sel_ls = lock_ls_q && ls_req_i;
                sel_if = !lock_ls_q && if_req_i;
            end else if (if_req_i && ls_req_i) begin
                if (starve_q == BurstMax) begin
                    sel_if = 1'b1;
                end else begin
                    sel_ls = 1'b1;
                end
            end else if (if_req_i) begin
                sel_if = 1'b1;
            end else if (ls_req_i) begin
                sel_ls = 1'b1;
            end
        end
    end

    // Reject invalid widths and misaligned half/word accesses.
    always_comb begin
        ls_bad = 1'b0;
        unique case (ls_width_i)
            WidthByte: ls_bad = 1'b0;
            WidthHalf: ls_bad = ls_addr_i[0];
            WidthWord: ls_bad = (ls_addr_i[1:0] != 2'b00);
            default:   ls_bad = 1'b1;
        endcase
    end

    assign bus_req = sel_if || (sel_ls && !ls_bad);

    // Store byte enables and lane-replicated write data; loads read the full word.
    always_comb begin
        ls_be    = 4'b1111;
        ls_wdata = ls_wdata_i;
        if (!ls_rw_i) begin
            unique case (ls_width_i)
                WidthByte: begin
                    ls_be    = 4'b0001 << ls_addr_i[1:0];
                    ls_wdata = {4{ls_wdata_i[7:0]}};
                end
                WidthHalf: begin
                    ls_be    = 4'b0011 << ls_addr_i[1:0];
                    ls_wdata = {2{ls_wdata_i[15:0]}};
                end
                default: begin
                    ls_be    = 4'b1111;
                    ls_wdata = ls_wdata_i;
                end
            endcase
        end
    end

    // Load alignment and sign/zero extension from the registered attributes.
    always_comb begin
        ld_shift = bus_rdata_i >> {off_q, 3'b000};
        ld_data  = bus_rdata_i;
        unique case (width_q)
            WidthByte: ld_data = rdtype_q ? {24'b0, ld_shift[7:0]}
                                          : {{24{ld_shift[7]}}, ld_shift[7:0]};
            WidthHalf: ld_data = rdtype_q ? {16'b0, ld_shift[15:0]}
                                          : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default:   ld_data = bus_rdata_i;
        endcase
    end

    // FSM next state, starve counter, lock and all outputs (zeroed during reset).
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        lock_d    = 1'b0;
        lock_ls_d = lock_ls_q;
        rw_d      = rw_q;
        rdtype_d  = rdtype_q;
        width_d   = width_q;
        off_d     = off_q;

        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = 32'b0;
        ls_gnt_o    = 1'b0;
        ls_err_o    = 1'b0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = 32'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'b0;
        bus_be_o    = 4'b0;
        bus_wdata_o = 32'b0;

        if (!rst_n) begin
            if_rdata_o = bus_rdata_i;

            unique case (state_q)
                StIdle: begin
                    bus_req_o = bus_req;
                    if (sel_if) begin
                        bus_addr_o = {if_addr_i[31:2], 2'b00};
                        bus_be_o   = 4'b1111;
                        if_gnt_o   = bus_gnt_i;
                        if (bus_gnt_i) begin
                            state_d = StWaitI;
                        end
                    end else if (sel_ls && ls_bad) begin
                        ls_gnt_o = 1'b1;
                        ls_err_o = 1'b1;
                    end else if (sel_ls) begin
                        bus_we_o    = !ls_rw_i;
                        bus_addr_o  = {ls_addr_i[31:2], 2'b00};
                        bus_be_o    = ls_be;
                        bus_wdata_o = ls_rw_i ? 32'b0 : ls_wdata;
                        ls_gnt_o    = bus_gnt_i;
                        if (bus_gnt_i) begin
                            state_d  = StWaitD;
                            rw_d     = ls_rw_i;
                            rdtype_d = ls_rdtype_i;
                            width_d  = ls_width_i;
                            off_d    = ls_addr_i[1:0];
                        end
                    end
                    if (bus_req && !bus_gnt_i) begin
                        lock_d    = 1'b1;
                        lock_ls_d = sel_ls;
                    end
                end
                StWaitI: begin
                    if (bus_rvalid_i) begin
                        if_rvalid_o = 1'b1;
                        state_d     = StIdle;
                    end
                end
                StWaitD: begin
                    if (bus_rvalid_i) begin
                        ls_rvalid_o = 1'b1;
                        ls_rdata_o  = rw_q ? ld_data : 32'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Counts LS bus grants while fetch waits; rejections do not count.
            if (!if_req_i || if_gnt_o) begin
                starve_d = 4'd0;
            end else if (sel_ls && !ls_bad && bus_gnt_i && starve_q != BurstMax) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= StIdle;
            starve_q  <= 4'd0;
            lock_q    <= 1'b0;
            lock_ls_q <= 1'b0;
            rw_q      <= 1'b0;
            rdtype_q  <= 1'b0;
            width_q   <= 2'd0;
            off_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            lock_q    <= lock_d;
            lock_ls_q <= lock_ls_d;
            rw_q      <= rw_d;
            rdtype_q  <= rdtype_d;
            width_q   <= width_d;
            off_q     <= off_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory bus port between instruction fetch (IF) and the load/store path (LS). It sits between the fetch stage and LS on one side and the bus on the other. On the LS side it takes the width/rdtype/rw encoding produced by the control unit. It arbitrates between the two requesters, keeps one transaction outstanding, builds byte enables and write-lane data, and extracts and extends load data.

## Interface
- LS_BURST_MAX, 4: max consecutive LS grants while IF waits; range 1..15.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset; synchronous, active-high (rst_n=1 resets on the next edge).
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  32  fetch address, word-aligned (bits [1:0] ignored).
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid (one-cycle pulse).
- if_rdata_o  out  32  fetch data = bus_rdata_i.
- ls_req_i  in  1  load/store request; held with payload until ls_gnt_o.
- ls_rw_i  in  1  1 = load, 0 = store.
- ls_width_i  in  2  1 = byte, 2 = half, 3 = word, 0 = invalid.
- ls_rdtype_i  in  1  0 = sign-extend, 1 = zero-extend (loads only).
- ls_addr_i  in  32  byte address.
- ls_wdata_i  in  32  store data, right-aligned.
- ls_gnt_o  out  1  LS request accepted or rejected this cycle.
- ls_err_o  out  1  misaligned/invalid request rejected (pulse, coincides with ls_gnt_o).
- ls_rvalid_o  out  1  load data ready / store acknowledged (pulse).
- ls_rdata_o  out  32  aligned, extended load data.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word address ({addr[31:2],2'b00}).
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated write data.
- bus_gnt_i  in  1  bus accepts request this cycle.
- bus_rvalid_i  in  1  response for the outstanding transaction.
- bus_rdata_i  in  32  read data, full word.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT_I: one IF transaction outstanding.
  - WAIT_D: one LS transaction outstanding.
- IDLE selection:
  - With one requester, that requester is selected.
  - With both requesting, LS is selected unless starve_cnt == LS_BURST_MAX; then IF is selected.
- bus_req_o = 1 only in IDLE with a selected, non-rejected request. The payload is muxed combinationally from the selected requester.
- Grant passthrough: the selected requester's gnt = bus_gnt_i.
  - On the grant, go to WAIT_I or WAIT_D.
  - For LS, register ls_rw_i, ls_width_i, ls_rdtype_i and ls_addr_i[1:0].
- starve_cnt (4 bits):
  - +1 on each LS grant while if_req_i = 1.
  - Cleared on an IF grant, or in any cycle where if_req_i = 0.
  - Saturates at LS_BURST_MAX.
- LS rejection (IDLE, LS selected): ls_width_i == 0, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Response: ls_gnt_o = ls_err_o = 1 for one cycle, bus_req_o = 0, state stays IDLE.
  - A rejection does not count toward starve_cnt.
- Write lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111.
- IF and LS loads use bus_we_o = 0 and bus_be_o = 4'b1111.
- WAIT_x on bus_rvalid_i: pulse the owner's rvalid the same cycle and return to IDLE. No bus_req_o in that cycle.
- Load extraction: sh = bus_rdata_i >> (8*off).
  - byte: result = sh[7:0], extended by rdtype.
  - half: result = sh[15:0], extended by rdtype.
  - word: result = bus_rdata_i.
- A store response pulses ls_rvalid_o; ls_rdata_o is then 0.
- bus_rvalid_i in IDLE is ignored: no output pulse.

## Timing
- Request accepted in the same cycle as bus_gnt_i (0-cycle added latency).
- Response is combinational: if_rvalid_o / ls_rvalid_o fire in the bus_rvalid_i cycle.
- Minimum spacing between two bus requests is 2 cycles: grant → rvalid ≥ 1 cycle later → IDLE → next request.
- A requester must hold req and payload stable until gnt. The arbiter does not re-arbitrate while bus_req_o is asserted and ungranted, so the selection is locked until bus_gnt_i.
- Reset:
  - Forces state = IDLE, starve_cnt = 0 and the lock cleared.
  - While rst_n = 1, all outputs are 0 (gnt, rvalid, err, bus_req_o, be, data).
- Reset mid-transaction drops the outstanding response. A late bus_rvalid_i after reset is ignored.

## Test plan
- IF only, if_addr_i = 0x100, bus_gnt_i immediate, rvalid 2 cycles later with data 0xDEADBEEF → if_gnt_o the same cycle, if_rvalid_o with if_rdata_o = 0xDEADBEEF, bus_be_o = 4'hF.
- LS load byte, addr 0x203, rdtype 0, bus data 0x80FFFFFF → bus_addr_o = 0x200, ls_rdata_o = 0xFFFFFF80; with rdtype 1 → 0x00000080.
- LS store half, addr 0x102, wdata 0x1234ABCD → bus_be_o = 4'b1100, bus_wdata_o = 0xABCDABCD, bus_we_o = 1, ls_rvalid_o on ack.
- Misaligned word load at 0x101 → ls_gnt_o = ls_err_o = 1 for one cycle, no bus_req_o, state IDLE. Repeat with ls_width_i = 0 for the same response.
- Both requesting continuously, 1-cycle bus responses, LS_BURST_MAX = 4 → grant order LS,LS,LS,LS,IF, repeating.
- rst_n asserted in WAIT_D, bus_rvalid_i arrives the cycle after reset release → no ls_rvalid_o, next request arbitrated from IDLE.
